// File: rtl/bless_inject_ctrl_pkg.sv
// Shared definitions for the BLESS local injection controller.
// Provides the router flit width, network port count, FSM state encodings
// and a helper that counts valid network flits.
package bless_inject_ctrl_pkg;

  localparam int unsigned FLIT_W = 16;

  localparam int unsigned NUM_NET_PORTS = 4;

  // FSM encodings kept numerically identical to the router-side definitions.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_STARVED = 2'd2;

  // Number of set bits in a network-valid vector (0..NUM_NET_PORTS).
  function automatic logic [2:0] count_valid(input logic [NUM_NET_PORTS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_NET_PORTS; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/bless_inject_ctrl_fifo.sv
// inject_fifo: synchronous FIFO buffering PE flits ahead of router injection.
// Ports:
//   clk, reset      clock, asynchronous active-low reset (clears pointers/count)
//   push_i, din_i   write request and data (ignored when full)
//   pop_i           read request (ignored when empty)
//   head_o          oldest entry (undefined content when empty)
//   count_o         occupancy 0..DEPTH
//   full_o, empty_o occupancy flags
module inject_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally at DEPTH (power of two); count tells full from empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/bless_inject_ctrl.sv
// bless_inject_ctrl: local injection scheduler between the PE and the BLESS
// router local input. Queues PE flits and injects the head flit whenever fewer
// than four network flits arrive this cycle. Flags head-of-line starvation.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   pe_flit, pe_valid          flit offered by the PE (all-zero = illegal)
//   pe_ready                   FIFO has room (registered occupancy only)
//   net_w/e/s/n                same-cycle router network inputs, nonzero = valid
//   dout_local, inject         flit driven to router dinLocal (zero when idle)
//   starve                     head flit blocked STARVE_LIMIT consecutive cycles
//   err_zero_flit              sticky: PE offered an all-zero flit
//   fifo_count                 current FIFO occupancy
module bless_inject_ctrl
  import bless_inject_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FLIT_W-1:0]      pe_flit,
  input  logic                   pe_valid,
  output logic                   pe_ready,
  input  logic [FLIT_W-1:0]      net_w,
  input  logic [FLIT_W-1:0]      net_e,
  input  logic [FLIT_W-1:0]      net_s,
  input  logic [FLIT_W-1:0]      net_n,
  output logic [FLIT_W-1:0]      dout_local,
  output logic                   inject,
  output logic                   starve,
  output logic                   err_zero_flit,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [7:0]  BLK_LAST = 8'(STARVE_LIMIT - 1);

  logic [1:0]              state_q, state_d;
  logic [7:0]              blk_q, blk_d;
  logic                    err_q, err_d;

  logic [NUM_NET_PORTS-1:0] net_valid;
  logic [2:0]              net_busy;
  logic                    grant, push, blocked, full, empty;
  logic [FLIT_W-1:0]       head;
  logic [CW-1:0]           cnt_after;

  inject_fifo #(
    .W     (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (grant),
    .din_i   (pe_flit),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign net_valid = {|net_n, |net_s, |net_e, |net_w};
  assign net_busy  = count_valid(net_valid);

  assign pe_ready  = ~full;
  assign push      = pe_valid & pe_ready & (|pe_flit);
  assign grant     = ~empty & (net_busy != 3'(NUM_NET_PORTS));
  assign blocked   = ~empty & ~grant;
  assign cnt_after = fifo_count + CW'(push) - CW'(grant);

  // Gated by the async-reset count, so dout_local drops with reset assertion.
  assign inject     = grant;
  assign dout_local = grant ? head : '0;

  assign starve        = (state_q == ST_STARVED);
  assign err_zero_flit = err_q;
  assign err_d         = err_q | (pe_valid & ~(|pe_flit));

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    case (state_q)
      ST_IDLE: begin
        if (push) state_d = ST_WAIT;
      end
      ST_WAIT, ST_STARVED: begin
        if (grant) begin
          blk_d   = '0;
          state_d = (cnt_after != '0) ? ST_WAIT : ST_IDLE;
        end else if (blocked) begin
          blk_d = (blk_q == 8'hFF) ? blk_q : blk_q + 8'd1;
          // Value before increment equals LIMIT-1 on the LIMIT-th blocked cycle.
          if (blk_q == BLK_LAST) state_d = ST_STARVED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bless_inject_ctrl.sv
// Self-checking bench for bless_inject_ctrl: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_bless_inject_ctrl;
  import bless_inject_ctrl_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 8;

  logic                   clk;
  logic                   reset;
  logic [FLIT_W-1:0]      pe_flit;
  logic                   pe_valid;
  logic                   pe_ready;
  logic [FLIT_W-1:0]      net_w, net_e, net_s, net_n;
  logic [FLIT_W-1:0]      dout_local;
  logic                   inject;
  logic                   starve;
  logic                   err_zero_flit;
  logic [$clog2(DEPTH):0] fifo_count;

  bless_inject_ctrl #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pe_flit       (pe_flit),
    .pe_valid      (pe_valid),
    .pe_ready      (pe_ready),
    .net_w         (net_w),
    .net_e         (net_e),
    .net_s         (net_s),
    .net_n         (net_n),
    .dout_local    (dout_local),
    .inject        (inject),
    .starve        (starve),
    .err_zero_flit (err_zero_flit),
    .fifo_count    (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Reference model: pending flits, sticky error, blocked-cycle run length.
  logic [FLIT_W-1:0] q[$];
  bit                err_m;
  int unsigned       run_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    q.delete();
    err_m = 0;
    run_m = 0;
  endtask

  // Drive one cycle of inputs, check outputs before the edge, advance model.
  task automatic cycle(input logic v, input logic [FLIT_W-1:0] f,
                       input logic [FLIT_W-1:0] w, input logic [FLIT_W-1:0] e,
                       input logic [FLIT_W-1:0] s, input logic [FLIT_W-1:0] n);
    int  busy;
    bit  g, p;
    int  sz;
    logic [FLIT_W-1:0] exp_out;
    pe_valid = v; pe_flit = f;
    net_w = w; net_e = e; net_s = s; net_n = n;
    #1;
    busy = int'(w != 0) + int'(e != 0) + int'(s != 0) + int'(n != 0);
    sz   = q.size();
    g    = (sz > 0) && (busy < 4);
    p    = v && (f != 0) && (sz < DEPTH);
    exp_out = '0;
    if (g) exp_out = q[0];
    chk("pe_ready",   32'(pe_ready),      32'(sz < DEPTH));
    chk("inject",     32'(inject),        32'(g));
    chk("dout_local", 32'(dout_local),    32'(exp_out));
    chk("starve",     32'(starve),        32'(run_m >= LIMIT));
    chk("fifo_count", 32'(fifo_count),    32'(sz));
    chk("err_zero",   32'(err_zero_flit), 32'(err_m));
    @(posedge clk);
    if (g) void'(q.pop_front());
    if (p) q.push_back(f);
    if (v && f == 0) err_m = 1;
    if (g) run_m = 0;
    else if (sz > 0) run_m++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    pe_valid = 0; pe_flit = '0;
    net_w = '0; net_e = '0; net_s = '0; net_n = '0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    chk("rst_dout",   32'(dout_local), 32'h0);
    chk("rst_inject", 32'(inject),     32'h0);
    chk("rst_starve", 32'(starve),     32'h0);
    chk("rst_count",  32'(fifo_count), 32'h0);
    chk("rst_ready",  32'(pe_ready),   32'h1);
    chk("rst_err",    32'(err_zero_flit), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [FLIT_W-1:0] rnd_flit();
    return FLIT_W'($urandom_range(1, (1 << FLIT_W) - 1));
  endfunction

  localparam logic [FLIT_W-1:0] B = 1; // any nonzero network flit

  initial begin
    int unsigned storm;
    logic        v;
    logic [FLIT_W-1:0] f, w, e, s, n;

    reset = 1'b0;
    idle_inputs();
    model_clear();
    @(negedge clk);
    do_reset();

    // Single flit, free network: injects the cycle after the push edge.
    cycle(1, 16'hA5, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Fill with all ports busy, overflow attempt, then drain in order.
    for (int i = 1; i <= 4; i++) cycle(1, FLIT_W'(i), B, B, B, B);
    cycle(1, 16'h55, B, B, B, B);
    for (int i = 0; i < 5; i++) cycle(0, 0, B, B, B, 0);

    // Starvation: one flit held back by a full network, then released.
    cycle(1, 16'h33, B, B, B, B);
    for (int i = 0; i < 10; i++) cycle(0, 0, B, B, B, B);
    cycle(0, 0, 0, B, B, B);
    cycle(0, 0, B, B, B, B);

    // Three busy ports: pop and push in the same cycle.
    cycle(1, 16'h11, B, B, B, B);
    cycle(1, 16'h07, B, B, B, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Zero flit is rejected and the error flag is sticky.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 16'h22, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Reset with three queued flits and starvation active.
    for (int i = 0; i < 3; i++) cycle(1, FLIT_W'(16'h40 + i), B, B, B, B);
    for (int i = 0; i < 9; i++) cycle(0, 0, B, B, B, B);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional full-network storms.
    for (int ep = 0; ep < 3; ep++) begin
      storm = 0;
      for (int c = 0; c < 400; c++) begin
        if (storm == 0 && $urandom_range(0, 29) == 0) storm = $urandom_range(5, 14);
        v = ($urandom_range(0, 9) < 6);
        f = ($urandom_range(0, 19) == 0) ? '0 : rnd_flit();
        if (storm > 0) begin
          w = B; e = B; s = B; n = B;
          storm--;
        end else begin
          w = $urandom_range(0, 1) ? rnd_flit() : '0;
          e = $urandom_range(0, 1) ? rnd_flit() : '0;
          s = $urandom_range(0, 1) ? rnd_flit() : '0;
          n = $urandom_range(0, 1) ? rnd_flit() : '0;
        end
        cycle(v, f, w, e, s, n);
      end
      do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
